// File: rtl/div_unit_pkg.sv
// Shared types and constants for the HI/LO divider: FSM state encoding and
// control-level literals used by EX when talking to div_unit.
package div_unit_pkg;

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      BY_ZERO = 2'd1,
      ON      = 2'd2,
      END     = 2'd3
   } div_state_t;

   localparam logic        DivResultReady    = 1'b1;
   localparam logic        DivResultNotReady = 1'b0;
   localparam logic        DivStart          = 1'b1;
   localparam logic        DivStop           = 1'b0;
   localparam logic [31:0] ZeroWord          = 32'h0000_0000;
   localparam int          DoubleRegBus      = 64;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result_o = {remainder, quotient} held while ready_o is high.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   div_state_t          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
   logic                neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0] result_q, result_d;
   logic                ready_q, ready_d;

   logic                accept, a_neg, b_neg, last_step;
   logic [DATA_W:0]     rem_sh, trial;
   logic [DATA_W-1:0]   rem_step, quo_step, rem_fix, quo_fix;

   assign accept = (start_i == DivStart) && !annul_i;
   assign a_neg  = signed_div_i & opdata1_i[DATA_W-1];
   assign b_neg  = signed_div_i & opdata2_i[DATA_W-1];

   // One step: the extra MSB keeps a full-width unsigned remainder from overflowing the shift.
   always_comb begin
      rem_sh    = {rem_q, quo_q[DATA_W-1]};
      trial     = rem_sh - {1'b0, dvsr_q};
      if (!trial[DATA_W]) begin
         rem_step = trial[DATA_W-1:0];
         quo_step = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
         rem_step = rem_sh[DATA_W-1:0];
         quo_step = {quo_q[DATA_W-2:0], 1'b0};
      end
      quo_fix   = neg_quo_q ? -quo_step : quo_step;
      rem_fix   = neg_rem_q ? -rem_step : rem_step;
      last_step = (cnt_q == CNT_W'(DATA_W - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FREE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         ready_q   <= DivResultNotReady;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FREE:    if (accept) state_d = (opdata2_i == '0) ? BY_ZERO : ON;
         BY_ZERO: state_d = END;
         ON: begin
            if (annul_i)        state_d = FREE;
            else if (last_step) state_d = END;
         end
         END:     if (start_i == DivStop) state_d = FREE;
         default: state_d = FREE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;
      case (state_q)
         FREE: begin
            if (accept && opdata2_i != '0) begin
               cnt_d     = '0;
               rem_d     = '0;
               quo_d     = a_neg ? -opdata1_i : opdata1_i;
               dvsr_d    = b_neg ? -opdata2_i : opdata2_i;
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
            end
         end
         BY_ZERO: begin
            result_d = '0;
            ready_d  = DivResultReady;
         end
         ON: begin
            if (annul_i) begin
               result_d = '0;
               ready_d  = DivResultNotReady;
            end else begin
               rem_d = rem_step;
               quo_d = quo_step;
               cnt_d = cnt_q + 1'b1;
               if (last_step) begin
                  result_d = {rem_fix, quo_fix};
                  ready_d  = DivResultReady;
               end
            end
         end
         END: begin
            if (start_i == DivStop) begin
               result_d = '0;
               ready_d  = DivResultNotReady;
            end
         end
         default: ;
      endcase
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule
